// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one recoded digit per clock, signed or
// unsigned operands, full-width product returned as hi/lo words.
module booth_r4_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int ACC_W  = 2 * WIDTH + 4;
  localparam int Q_W    = WIDTH + 3;
  localparam int CNT_W  = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   m_reg;
  logic [Q_W-1:0]     q_reg;
  logic [ACC_W-1:0]   acc;

  logic [ACC_W-1:0]   m_ext;
  logic [Q_W-1:0]     q_ext;
  logic [ACC_W-1:0]   m_dbl;
  logic [ACC_W-1:0]   pp;
  logic [ACC_W-1:0]   acc_next;

  // m_reg is pre-shifted by 2i, so the partial product needs no barrel shifter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pp       = '0;
    m_ext    = is_signed ? {{(ACC_W - WIDTH){multiplicand[WIDTH-1]}}, multiplicand}
                         : {{(ACC_W - WIDTH){1'b0}}, multiplicand};
    q_ext    = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};
    m_dbl    = {m_reg[ACC_W-2:0], 1'b0};
    unique case (q_reg[2:0])
      3'b001, 3'b010: pp = m_reg;
      3'b011:         pp = m_dbl;
      3'b100:         pp = -m_dbl;
      3'b101, 3'b110: pp = -m_reg;
      default:        pp = '0;
    endcase
    acc_next = acc + pp;
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      m_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_reg <= m_ext;
            q_reg <= q_ext;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          m_reg <= {m_reg[ACC_W-3:0], 2'b00};
          q_reg <= {2'b00, q_reg[Q_W-1:2]};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(DIGITS - 1)) begin
            hi    <= acc_next[2*WIDTH-1:WIDTH];
            lo    <= acc_next[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
